// File: rtl/rga_bus_master_if.sv
`default_nettype none
// ============================================================================
// Interface : rga_bus_master_if
// Brief     : Request queue handshake plus RGA/DB register-bus signals seen
//             by the rga_bus_master initiator (master) and its peer (slave).
// Revision  : 1.0 - initial release
// ============================================================================
interface rga_bus_master_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          cck;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [7:0]    req_addr;
  logic [15:0]   req_data;
  logic [7:0]    rga;
  logic [15:0]   db_out;
  logic          db_oen;
  logic [15:0]   db_in;
  logic          rd_valid;
  logic [7:0]    rd_addr;
  logic [15:0]   rd_data;
  logic [LW-1:0] level;

  modport master (
    input  cck, req_valid, req_write, req_addr, req_data, db_in,
    output req_ready, rga, db_out, db_oen, rd_valid, rd_addr, rd_data, level
  );

  modport slave (
    output cck, req_valid, req_write, req_addr, req_data, db_in,
    input  req_ready, rga, db_out, db_oen, rd_valid, rd_addr, rd_data, level
  );
endinterface
`default_nettype wire

// File: rtl/rga_bus_master.sv
`default_nettype none
// ============================================================================
// Module    : rga_bus_master
// Brief     : Queues chip-register read/write requests and issues one per CCK
//             slot on RGA[8:1]/DB[15:0]: address from the rise, write data
//             driven in the low half, read data captured at the closing rise.
//             Optional macro RGA_READBACK_EN enables bus read cycles; without
//             it reads are dropped from the queue at pop time.
// Revision  : 1.0 - initial release
// ============================================================================
module rga_bus_master #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] IDLE_RGA   = 8'hFF
) (
  input  wire logic        clk,
  input  wire logic        rst,
  rga_bus_master_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          cck_d;
  logic          rise, fall, push;
  // Entry layout: [24] write, [23:16] addr[8:1], [15:0] data
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level, pop_cnt, cand_cnt;
  logic          cand_ok;
  logic [24:0]   cand, cur, cur_nxt;
  logic [7:0]    rga_r, rga_nxt;
  logic [15:0]   db_out_r, db_out_nxt;
  logic          db_oen_r, db_oen_nxt;

  assign rise = bus.cck & ~cck_d;
  assign fall = ~bus.cck & cck_d;
  // Ready looks at occupancy only, so a pop in the same clk never frees a slot early
  assign push = bus.req_valid & bus.req_ready;

  assign bus.req_ready = (level != FULL_LEVEL);
  assign bus.level     = level;
  assign bus.rga       = rga_r;
  assign bus.db_out    = db_out_r;
  assign bus.db_oen    = db_oen_r;

  // Queue storage write port (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.req_write, bus.req_addr, bus.req_data};
  end

  // Pick the entry a rise would issue and how many entries it consumes
  always_comb begin
    cand_ok  = 1'b0;
    cand     = mem[rd_ptr];
    cand_cnt = '0;
`ifdef RGA_READBACK_EN
    if (level != '0) begin
      cand_ok  = 1'b1;
      cand_cnt = LW'(1);
    end
`else
    // Reads ahead of the first write are discarded in the same pop
    cand_cnt = level;
    for (int i = FIFO_DEPTH - 1; i >= 0; i--) begin
      if ((LW'(i) < level) && mem[rd_ptr + AW'(i)][24]) begin
        cand_ok  = 1'b1;
        cand     = mem[rd_ptr + AW'(i)];
        cand_cnt = LW'(i + 1);
      end
    end
`endif
  end

`ifdef RGA_READBACK_EN
  logic        rd_valid_r, rd_valid_nxt;
  logic [7:0]  rd_addr_r, rd_addr_nxt;
  logic [15:0] rd_data_r, rd_data_nxt;

  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_addr  = rd_addr_r;
  assign bus.rd_data  = rd_data_r;

  // Read-return registers: one-clk pulse with the captured address/data
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_addr_r  <= '0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= rd_valid_nxt;
      rd_addr_r  <= rd_addr_nxt;
      rd_data_r  <= rd_data_nxt;
    end
  end
`else
  logic unused_bits;
  assign unused_bits  = ^{bus.db_in, cur[23:16]};
  assign bus.rd_valid = 1'b0;
  assign bus.rd_addr  = '0;
  assign bus.rd_data  = '0;
`endif

  // Bus-cycle sequencing: every rise closes the current slot and opens the next
  always_comb begin
    state_nxt  = state;
    pop_cnt    = '0;
    cur_nxt    = cur;
    rga_nxt    = rga_r;
    db_out_nxt = db_out_r;
    db_oen_nxt = db_oen_r;
`ifdef RGA_READBACK_EN
    rd_valid_nxt = 1'b0;
    rd_addr_nxt  = rd_addr_r;
    rd_data_nxt  = rd_data_r;
`endif
    if (rise) begin
      // A rise in ADDR (missed fall) also closes the slot, without write drive
`ifdef RGA_READBACK_EN
      if ((state != S_IDLE) && !cur[24]) begin
        rd_valid_nxt = 1'b1;
        rd_addr_nxt  = cur[23:16];
        rd_data_nxt  = bus.db_in;
      end
`endif
      db_oen_nxt = 1'b0;
      pop_cnt    = cand_cnt;
      if (cand_ok) begin
        state_nxt = S_ADDR;
        cur_nxt   = cand;
        rga_nxt   = cand[23:16];
      end else begin
        state_nxt = S_IDLE;
        rga_nxt   = IDLE_RGA;
      end
    end else if (fall && (state == S_ADDR)) begin
      if (cur[24]) begin
        db_out_nxt = cur[15:0];
        db_oen_nxt = 1'b1;
      end
      state_nxt = S_DATA;
    end
  end

  // State, queue pointers and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cck_d    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      cur      <= '0;
      rga_r    <= IDLE_RGA;
      db_out_r <= '0;
      db_oen_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      cck_d    <= bus.cck;
      rd_ptr   <= rd_ptr + pop_cnt[AW-1:0];
      wr_ptr   <= wr_ptr + AW'(push);
      level    <= level + LW'(push) - pop_cnt;
      cur      <= cur_nxt;
      rga_r    <= rga_nxt;
      db_out_r <= db_out_nxt;
      db_oen_r <= db_oen_nxt;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rga_bus_master.sv
`default_nettype none
// ============================================================================
// Module    : tb_rga_bus_master
// Brief     : Self-checking bench for rga_bus_master. A transaction-level model
//             (request queue plus the request owning the current CCK slot)
//             predicts every registered output each clk.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_rga_bus_master;
  localparam int DEPTH = 4;
`ifdef RGA_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef struct packed {
    logic        w;
    logic [7:0]  a;
    logic [15:0] d;
  } req_t;

  logic clk = 1'b0;
  logic rst;

  rga_bus_master_if #(.FIFO_DEPTH(DEPTH)) bus ();

  rga_bus_master #(.FIFO_DEPTH(DEPTH), .IDLE_RGA(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: pending requests, the request owning the slot, last registered outputs
  req_t        mq[$];
  req_t        cur;
  bit          cur_v;
  bit          m_cck;
  logic [7:0]  m_rga;
  logic        m_oen;
  logic [15:0] m_out;
  logic        m_rdv;
  logic [7:0]  m_rda;
  logic [15:0] m_rdd;

  bit cck_lvl  = 1'b0;
  int cck_left = 0;

  function automatic bit cck_gen(input int hi, input int lo);
    if (cck_left <= 0) begin
      cck_lvl  = ~cck_lvl;
      cck_left = cck_lvl ? hi : lo;
    end
    cck_left--;
    return cck_lvl;
  endfunction

  function automatic logic [63:0] observed();
    return {bus.rga, bus.db_oen, (bus.db_oen ? bus.db_out : 16'h0),
            bus.rd_valid, (bus.rd_valid ? {bus.rd_addr, bus.rd_data} : 24'h0),
            8'(bus.level), bus.req_ready, 5'b0};
  endfunction

  function automatic logic [63:0] expected();
    return {m_rga, m_oen, (m_oen ? m_out : 16'h0),
            m_rdv, (m_rdv ? {m_rda, m_rdd} : 24'h0),
            8'(mq.size()), (mq.size() < DEPTH), 5'b0};
  endfunction

  // Drive one clk of inputs at a negedge, advance the model to the coming
  // posedge, then wait for the next negedge where outputs are sampled.
  task automatic tick(input bit do_rst, input bit c, input bit pv, input req_t rq,
                      input logic [15:0] dbi);
    int sz0;
    bit rs, fl;
    rst           = do_rst;
    bus.cck       = c;
    bus.req_valid = pv;
    bus.req_write = rq.w;
    bus.req_addr  = rq.a;
    bus.req_data  = rq.d;
    bus.db_in     = dbi;
    sz0   = mq.size();
    m_rdv = 1'b0;
    if (do_rst) begin
      mq.delete();
      cur_v = 1'b0;
      m_cck = 1'b0;
      m_rga = 8'hFF;
      m_oen = 1'b0;
      m_out = 16'h0;
      m_rda = 8'h0;
      m_rdd = 16'h0;
    end else begin
      rs    = c && !m_cck;
      fl    = !c && m_cck;
      m_cck = c;
      if (rs) begin
        if (cur_v && !cur.w && READBACK) begin
          m_rdv = 1'b1;
          m_rda = cur.a;
          m_rdd = dbi;
        end
        m_oen = 1'b0;
        cur_v = 1'b0;
        while (mq.size() > 0 && !cur_v) begin
          cur = mq.pop_front();
          if (cur.w || READBACK) cur_v = 1'b1;
        end
        m_rga = cur_v ? cur.a : 8'hFF;
      end else if (fl && cur_v && cur.w) begin
        m_oen = 1'b1;
        m_out = cur.d;
      end
      if (pv && sz0 < DEPTH) mq.push_back(rq);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) tick(1'b1, cck_gen(8, 8), 1'b0, '0, 16'h0);
    checks++;
    if (bus.rga !== 8'hFF) begin errors++; $display("FAIL reset_rga got=%h want=ff", bus.rga); end
    checks++;
    if (bus.db_oen !== 1'b0) begin errors++; $display("FAIL reset_oen got=%b want=0", bus.db_oen); end
    checks++;
    if (bus.level !== '0) begin errors++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
    checks++;
    if (bus.db_out !== 16'h0 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_db_rd got=%h/%b want=0000/0", bus.db_out, bus.rd_valid);
    end
  endtask

  task automatic test_single_write();
    req_t rq;
    int   seen = 0;
    rq = '{w: 1'b1, a: 8'h90, d: 16'h0F00};
    for (int k = 0; k < 48; k++) begin
      tick(1'b0, cck_gen(8, 8), (k == 1), rq, 16'h0);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL single_write clk=%0d got=%h want=%h", cyc, observed(), expected());
      end
      if (bus.rga === 8'h90 && bus.db_oen === 1'b1 && bus.db_out === 16'h0F00) seen++;
    end
    checks++;
    if (seen != 8) begin errors++; $display("FAIL single_write_drive got=%0d want=8 clks", seen); end
    checks++;
    if (bus.rga !== 8'hFF) begin errors++; $display("FAIL single_write_idle got=%h want=ff", bus.rga); end
  endtask

  task automatic test_back_to_back();
    req_t       rq;
    logic [7:0] prev;
    logic [7:0] seq[$];
    logic [7:0] want[5];
    int         guard = 0;
    want = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hFF};
    // Align to just after a rise so four pushes land inside one high half
    while (!(cck_lvl && cck_left == 7) && guard < 40) begin
      tick(1'b0, cck_gen(8, 8), 1'b0, '0, 16'h0);
      guard++;
    end
    for (int k = 0; k < 4; k++) begin
      rq = '{w: 1'b1, a: 8'hC0 + 8'(k), d: 16'h1000 + 16'(k)};
      tick(1'b0, cck_gen(8, 8), 1'b1, rq, 16'h0);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL b2b_fill clk=%0d got=%h want=%h", cyc, observed(), expected());
      end
    end
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got=%b want=0", bus.req_ready); end
    prev = bus.rga;
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, cck_gen(8, 8), 1'b0, '0, 16'h0);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL b2b_run clk=%0d got=%h want=%h", cyc, observed(), expected());
      end
      if (bus.rga !== prev) seq.push_back(bus.rga);
      prev = bus.rga;
    end
    checks++;
    if (seq.size() != 5) begin
      errors++; $display("FAIL b2b_slots got=%0d rga changes want=5", seq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (seq[k] !== want[k]) begin
          errors++; $display("FAIL b2b_slot%0d got=%h want=%h", k, seq[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_read();
    req_t rq;
    int   pulses = 0, oen_clks = 0, addr_clks = 0;
    rq = '{w: 1'b0, a: 8'h3E, d: 16'h5555};
    for (int k = 0; k < 60; k++) begin
      tick(1'b0, cck_gen(8, 8), (k == 2), rq, 16'hFFFC);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL read clk=%0d got=%h want=%h", cyc, observed(), expected());
      end
      if (bus.db_oen === 1'b1) oen_clks++;
      if (bus.rga === 8'h3E) addr_clks++;
      if (bus.rd_valid === 1'b1) begin
        pulses++;
        checks++;
        if (bus.rd_addr !== 8'h3E || bus.rd_data !== 16'hFFFC) begin
          errors++; $display("FAIL read_data got=%h/%h want=3e/fffc", bus.rd_addr, bus.rd_data);
        end
      end
    end
    checks++;
    if (pulses != int'(READBACK)) begin
      errors++; $display("FAIL read_pulses got=%0d want=%0d", pulses, int'(READBACK));
    end
    checks++;
    if (oen_clks != 0) begin errors++; $display("FAIL read_oen got=%0d clks want=0", oen_clks); end
    checks++;
    if ((addr_clks != 0) != READBACK) begin
      errors++; $display("FAIL read_slot got=%0d addr clks want_used=%0d", addr_clks, READBACK);
    end
  endtask

  task automatic test_reset_mid_write();
    req_t rq;
    int   guard = 0, stray = 0;
    for (int k = 0; k < 3; k++) begin
      rq = '{w: 1'b1, a: 8'hA5 + 8'(k), d: 16'hBEE0 + 16'(k)};
      tick(1'b0, cck_gen(8, 8), 1'b1, rq, 16'h0);
    end
    while (bus.db_oen !== 1'b1 && guard < 60) begin
      tick(1'b0, cck_gen(8, 8), 1'b0, '0, 16'h0);
      guard++;
    end
    checks++;
    if (bus.db_oen !== 1'b1) begin
      errors++; $display("FAIL midrst_drive got=%b want=1 within 60 clks", bus.db_oen);
    end
    tick(1'b1, cck_gen(8, 8), 1'b0, '0, 16'h0);
    checks++;
    if (bus.db_oen !== 1'b0 || bus.rga !== 8'hFF || bus.level !== '0) begin
      errors++; $display("FAIL midrst_release got=%b/%h/%0d want=0/ff/0", bus.db_oen, bus.rga, bus.level);
    end
    for (int k = 0; k < 40; k++) begin
      tick(1'b0, cck_gen(8, 8), 1'b0, '0, 16'h0);
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL midrst_after clk=%0d got=%h want=%h", cyc, observed(), expected());
      end
      if (bus.rga !== 8'hFF || bus.db_oen !== 1'b0 || bus.rd_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL midrst_flushed got=%0d busy clks want=0", stray); end
  endtask

  task automatic test_random();
    req_t rq;
    bit   pv;
    for (int k = 0; k < 800; k++) begin
      rq.w = 1'($urandom_range(0, 1));
      rq.a = 8'($urandom);
      rq.d = 16'($urandom);
      pv   = ($urandom_range(0, 2) == 0);
      tick(1'b0, cck_gen(int'($urandom_range(2, 6)), int'($urandom_range(2, 6))), pv, rq,
           16'($urandom));
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL random clk=%0d got=%h want=%h", cyc, observed(), expected());
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cck       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h0;
    bus.req_data  = 16'h0;
    bus.db_in     = 16'h0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
